exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_pkg.sv | 48 ++++
 rtl/exec_if.sv | 35 +++
 rtl/exec_mul_iter.sv | 64 ++++++
 rtl/exec_unit.sv | 164 ++++++++++++++++
 tb/tb_exec_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module : exec_pkg
// Desc   : Shared types and constants for the execution unit: opcode and
//          state enumerations, default widths, multiplier iteration count and
//          an opcode legality helper.
// Config : EXEC_MUL_EN - when defined, MUL (opcode 9) is legal and the MUL
//          state exists.
// Rev    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_ADDR_W_DEFAULT = 5;
    localparam int c_MUL_ITERS      = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_WB   = 2'd2
    } state_e;

    // Opcodes above the last supported one are accepted but flagged illegal.
    function automatic logic op_is_legal(input logic [3:0] op);
`ifdef EXEC_MUL_EN
        return (op <= 4'd9);
`else
        return (op <= 4'd8);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_if.sv
`default_nettype none
// ============================================================================
// Module : exec_if
// Desc   : Operation request / register-file write bus of the execution unit.
//          master = issuing side, slave = execution unit.
// Rev    : 1.0 - initial release
// ============================================================================
interface exec_if
    import exec_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int ADDR_W = c_ADDR_W_DEFAULT
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] y_data;
    logic [ADDR_W-1:0] dest;
    logic              RegWrite;
    logic [ADDR_W-1:0] z_write;
    logic [DATA_W-1:0] z_data;
    logic              illegal_op;

    modport master (
        output in_valid, op, x_data, y_data, dest,
        input  in_ready, RegWrite, z_write, z_data, illegal_op
    );

    modport slave (
        input  in_valid, op, x_data, y_data, dest,
        output in_ready, RegWrite, z_write, z_data, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/exec_mul_iter.sv
`default_nettype none
// ============================================================================
// Module : exec_mul_iter
// Desc   : Iterative shift-add multiplier, one multiplier bit per cycle.
//          start loads the operands; after ITERS cycles done rises and result
//          holds the low DATA_W bits of the unsigned product. done stays high
//          until the next start.
// Rev    : 1.0 - initial release
// ============================================================================
module exec_mul_iter #(
    parameter int DATA_W = 32,
    parameter int ITERS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int c_CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    // Load on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_CNT_W'(ITERS - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done   = r_done;
    assign result = r_acc;
endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// Module : exec_unit
// Desc   : Single-issue execution unit. Accepts one operation when idle,
//          computes it (one cycle for ALU ops, 33 cycles for MUL) and issues a
//          single register-file write. Unsupported opcodes pulse illegal_op.
// Config : EXEC_MUL_EN - compiles in the iterative multiplier and MUL state;
//          otherwise opcode 9 is illegal.
// Rev    : 1.0 - initial release
// ============================================================================
module exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
    input  logic  clock,
    input  logic  reset,
    exec_if.slave bus
);
    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_wr_load;
    logic              w_illegal;
    logic [DATA_W-1:0] w_alu;
    logic [4:0]        w_shamt;
    logic [ADDR_W-1:0] w_dest;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [ADDR_W-1:0] r_z_write;
    logic [DATA_W-1:0] r_z_data;
    logic              r_illegal;

    assign w_shamt = bus.y_data[4:0];
    assign w_dest  = bus.dest;

`ifdef EXEC_MUL_EN
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_res;
    logic [ADDR_W-1:0] r_dest;

    exec_mul_iter #(
        .DATA_W (DATA_W),
        .ITERS  (c_MUL_ITERS)
    ) u_mul (
        .clock  (clock),
        .reset  (reset),
        .start  (w_mul_start),
        .a      (bus.x_data),
        .b      (bus.y_data),
        .done   (w_mul_done),
        .result (w_mul_res)
    );

    // Destination of a MUL must survive the iteration phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dest <= '0;
        end else if (w_mul_start) begin
            r_dest <= bus.dest;
        end
    end
`endif

    // Single-cycle ALU result from the live operands (used only on accept).
    always_comb begin
        w_alu = '0;
        case (op_e'(bus.op))
            OP_ADD:  w_alu = bus.x_data + bus.y_data;
            OP_SUB:  w_alu = bus.x_data - bus.y_data;
            OP_AND:  w_alu = bus.x_data & bus.y_data;
            OP_OR:   w_alu = bus.x_data | bus.y_data;
            OP_XOR:  w_alu = bus.x_data ^ bus.y_data;
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(bus.x_data) < $signed(bus.y_data))};
            OP_SLL:  w_alu = bus.x_data << w_shamt;
            OP_SRL:  w_alu = bus.x_data >> w_shamt;
            OP_SRA:  w_alu = DATA_W'($signed(bus.x_data) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // Next state plus the per-cycle load/pulse strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_load   = 1'b0;
        w_illegal   = 1'b0;
`ifdef EXEC_MUL_EN
        w_mul_start = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (!op_is_legal(bus.op)) begin
                        w_illegal = 1'b1;
                    end
`ifdef EXEC_MUL_EN
                    else if (bus.op == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end
`endif
                    else begin
                        w_wr_load   = 1'b1;
                        w_state_nxt = ST_WB;
                    end
                end
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
                if (w_mul_done) begin
                    w_wr_load   = 1'b1;
                    w_state_nxt = ST_WB;
                end
            end
`endif
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write-back source: live ALU result on accept, multiplier result leaving MUL.
    always_comb begin
        w_wr_addr = w_dest;
        w_wr_data = w_alu;
`ifdef EXEC_MUL_EN
        if (r_state == ST_MUL) begin
            w_wr_addr = r_dest;
            w_wr_data = w_mul_res;
        end
`endif
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write bus is loaded only when entering WB so it holds between writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_z_write <= '0;
            r_z_data  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
            if (w_wr_load) begin
                r_z_write <= w_wr_addr;
                r_z_data  <= w_wr_data;
            end
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.RegWrite   = (r_state == ST_WB);
    assign bus.z_write    = r_z_write;
    assign bus.z_data     = r_z_data;
    assign bus.illegal_op = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_exec_unit
// Desc   : Self-checking bench for exec_unit. Expected writes are queued when
//          an operation is issued and popped by the write monitor.
// Config : EXEC_MUL_EN - selects the MUL scenarios instead of the opcode-9
//          illegal scenario.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_exec_unit;
    localparam logic [3:0] T_ADD = 4'd0, T_SUB = 4'd1, T_AND = 4'd2, T_OR  = 4'd3,
                           T_XOR = 4'd4, T_SLT = 4'd5, T_SLL = 4'd6, T_SRL = 4'd7,
                           T_SRA = 4'd8, T_MUL = 4'd9;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    exec_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    exec_unit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   n_writes = 0;
    int   n_pushed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ext;
        logic [4:0]  sh;
        sh  = y[4:0];
        ext = {{32{x[31]}}, x} >> sh;
        case (op)
            T_ADD:   return x + y;
            T_SUB:   return x + ~y + 32'd1;
            T_AND:   return x & y;
            T_OR:    return x | y;
            T_XOR:   return x ^ y;
            T_SLT:   return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, (x < y)};
            T_SLL:   return x << sh;
            T_SRL:   return x >> sh;
            T_SRA:   return ext[31:0];
            default: return 32'd0;
        endcase
    endfunction

    // Write monitor: every RegWrite pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.RegWrite === 1'b1) begin
            exp_t e;
            n_writes++;
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.z_write), 32'(e.dest));
                check("wr_data", bus.z_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] d);
        bus.op       = op;
        bus.x_data   = x;
        bus.y_data   = y;
        bus.dest     = d;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] x,
                              input logic [31:0] y, input logic [4:0] d, input logic [31:0] exp);
        @(negedge clock);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        drive(op, x, y, d);
        sb.push_back('{dest: d, data: exp});
        n_pushed++;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        check({tag, "_wr"}, 32'(bus.RegWrite), 32'd1);
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        @(negedge clock);
        check({tag, "_wr_off"}, 32'(bus.RegWrite), 32'd0);
        check({tag, "_hold"}, bus.z_data, exp);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic [3:0] op, input logic [31:0] last_z);
        @(negedge clock);
        drive(op, 32'h1234_5678, 32'h0000_0003, 5'd9);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        @(negedge clock);
        check({tag, "_pulse"}, 32'(bus.illegal_op), 32'd1);
        check({tag, "_nowr"}, 32'(bus.RegWrite), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        check({tag, "_pulse_end"}, 32'(bus.illegal_op), 32'd0);
        check({tag, "_nowr2"}, 32'(bus.RegWrite), 32'd0);
        check({tag, "_zhold"}, bus.z_data, last_z);
    endtask

    initial begin
        int saved;
        int acc;
        logic [31:0] bx;

        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.x_data   = 32'd0;
        bus.y_data   = 32'd0;
        bus.dest     = 5'd0;

        // Reset state
        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("rst_illegal", 32'(bus.illegal_op), 32'd0);
        check("rst_zwrite", 32'(bus.z_write), 32'd0);
        check("rst_zdata", bus.z_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single-cycle operations
        run_single("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'h0000_0000);
        check("add_wrap_addr", 32'(bus.z_write), 32'd3);
        run_single("sub_dest0", T_SUB, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF);
        run_single("and", T_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7, model(T_AND, 32'hF0F0_1234, 32'h0FF0_FFFF));
        run_single("or", T_OR, 32'hA000_0005, 32'h0500_0A00, 5'd8, model(T_OR, 32'hA000_0005, 32'h0500_0A00));
        run_single("xor", T_XOR, 32'hFFFF_0000, 32'hF0F0_F0F0, 5'd31, model(T_XOR, 32'hFFFF_0000, 32'hF0F0_F0F0));
        run_single("slt_neg", T_SLT, 32'h8000_0000, 32'd1, 5'd4, 32'd1);
        run_single("slt_pos", T_SLT, 32'd1, 32'h8000_0000, 5'd4, model(T_SLT, 32'd1, 32'h8000_0000));
        run_single("sll", T_SLL, 32'd1, 32'd31, 5'd5, 32'h8000_0000);
        run_single("srl", T_SRL, 32'h8000_0000, 32'd4, 5'd6, 32'h0800_0000);
        run_single("sra", T_SRA, 32'h8000_0000, 32'd4, 5'd10, 32'hF800_0000);
        run_single("sra_shamt", T_SRA, 32'h8000_0000, 32'h0000_0024, 5'd11, model(T_SRA, 32'h8000_0000, 32'h0000_0024));

        // Illegal opcodes
        run_illegal("ill12", 4'd12, 32'hF800_0000);
`ifndef EXEC_MUL_EN
        run_illegal("ill9", T_MUL, 32'hF800_0000);
`else
        // MUL: 33 busy cycles then one write
        @(negedge clock);
        drive(T_MUL, 32'h0001_0001, 32'h0001_0001, 5'd7);
        sb.push_back('{dest: 5'd7, data: 32'h0002_0001});
        n_pushed++;
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        saved = 0;
        @(negedge clock);
        while (bus.in_ready === 1'b0 && bus.RegWrite === 1'b0 && saved < 100) begin
            saved++;
            @(negedge clock);
        end
        check("mul_busy_cycles", 32'(saved), 32'd33);
        check("mul_wr", 32'(bus.RegWrite), 32'd1);
        check("mul_data", bus.z_data, 32'h0002_0001);
        @(negedge clock);
        check("mul_wr_off", 32'(bus.RegWrite), 32'd0);
        check("mul_idle", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of a MUL: no write may follow
        @(negedge clock);
        drive(T_MUL, 32'd3, 32'd5, 5'd12);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("mulrst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("mulrst_ready", 32'(bus.in_ready), 32'd1);
        check("mulrst_zdata", bus.z_data, 32'd0);
        saved = n_writes;
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("mulrst_nowrite", 32'(n_writes), 32'(saved));
`endif

        // Reset during WB: the pending write is dropped
        @(negedge clock);
        drive(T_ADD, 32'd7, 32'd8, 5'd9);
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("wbrst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("wbrst_zwrite", 32'(bus.z_write), 32'd0);
        saved = n_writes;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("wbrst_nowrite", 32'(n_writes), 32'(saved));

        run_single("add_after_rst", T_ADD, 32'd2, 32'd3, 5'd1, 32'd5);

        // in_valid held high: only accepts in IDLE produce writes
        acc = 0;
        bx  = 32'd100;
        @(negedge clock);
        drive(T_ADD, bx, 32'd1, 5'd20);
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready === 1'b1) begin
                sb.push_back('{dest: bus.dest, data: bx + 32'd1});
                n_pushed++;
                acc++;
            end
            @(posedge clock);
            #1;
            bx          = bx + 32'd1;
            bus.x_data  = bx;
            bus.dest    = bus.dest + 5'd1;
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd5);
        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("write_count", 32'(n_writes), 32'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
